qlearn_episode_ctrl: RTL and testbench

- Sequences the Q-learning core across training episodes.
- Per episode: issues the start step from a first state, chooses each action epsilon-greedy with an internal LFSR, waits for the core's step-done strobe, and ends the episode on goal state or step limit.
- After NUM_EPISODES episodes, asserts finish to the core.
- Sits between the top-level run control and the core's i_start/i_valid/i_at/i_finish inputs.

---
 rtl/qlearn_episode_ctrl.sv | 135 +++++++++++++
 tb/tb_qlearn_episode_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qlearn_episode_ctrl.sv
// Episode sequencer for the Q-learning core: epsilon-greedy action choice from a 16-bit LFSR.
// Optional per-episode epsilon decay is compiled in when QLEARN_EPS_DECAY_EN is defined.
module qlearn_episode_ctrl #(
    parameter int unsigned   STATES_WIDTH  = 4,
    parameter int unsigned   ACTIONS_WIDTH = 2,
    parameter int unsigned   NUM_ACTIONS   = 3,
    parameter int unsigned   GOAL_STATE    = 15,
    parameter int unsigned   MAX_STEPS     = 64,
    parameter int unsigned   NUM_EPISODES  = 300,
    parameter logic [7:0]    EPS_INIT      = 8'd64,
    parameter logic [7:0]    EPS_STEP      = 8'd1,
    parameter logic [7:0]    EPS_MIN       = 8'd4,
    parameter logic [15:0]   SEED          = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_run,
    input  logic [STATES_WIDTH-1:0]  i_first_st,
    input  logic [ACTIONS_WIDTH-1:0] i_best_at,
    input  logic [STATES_WIDTH-1:0]  i_st,
    input  logic                     i_valid_max,
    output logic                     o_start,
    output logic                     o_valid,
    output logic [ACTIONS_WIDTH-1:0] o_at,
    output logic [STATES_WIDTH-1:0]  o_first_st,
    output logic                     o_finish,
    output logic                     o_busy,
    output logic [15:0]              o_episode_cnt,
    output logic [15:0]              o_step_cnt,
    output logic                     o_err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] ISSUE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [7:0]              NUM_ACT8  = 8'(NUM_ACTIONS);
    localparam logic [15:0]             MAX_ST16  = 16'(MAX_STEPS);
    localparam logic [15:0]             NUM_EP16  = 16'(NUM_EPISODES);
    localparam logic [STATES_WIDTH-1:0] GOAL      = STATES_WIDTH'(GOAL_STATE);

    logic [2:0]               state_q, state_d;
    logic [15:0]              lfsr_q;
    logic [7:0]               eps_q;
    logic [7:0]               explore_idx;
    logic [ACTIONS_WIDTH-1:0] choice;
    logic [15:0]              step_inc, ep_inc;
    logic                     step_done, ep_end, run_ok, pulse;

    assign step_inc    = o_step_cnt + 16'd1;
    assign ep_inc      = o_episode_cnt + 16'd1;
    assign step_done   = (state_q == WAIT) && i_valid_max;
    assign ep_end      = step_done && ((i_st == GOAL) || (step_inc == MAX_ST16));
    assign run_ok      = i_run && ((state_q == IDLE) || (state_q == DONE));
    assign pulse       = (state_d == START) || (state_d == ISSUE);
    assign explore_idx = lfsr_q[15:8] % NUM_ACT8;
    assign choice      = (lfsr_q[7:0] < eps_q) ? explore_idx[ACTIONS_WIDTH-1:0] : i_best_at;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (i_run) state_d = START;
            START:      state_d = WAIT;
            WAIT: begin
                if (ep_end) begin
                    state_d = (ep_inc == NUM_EP16) ? DONE : START;
                end else if (step_done) begin
                    state_d = ISSUE;
                end
            end
            ISSUE:      state_d = WAIT;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED;
            o_start       <= 1'b0;
            o_valid       <= 1'b0;
            o_at          <= '0;
            o_first_st    <= '0;
            o_finish      <= 1'b0;
            o_busy        <= 1'b0;
            o_episode_cnt <= '0;
            o_step_cnt    <= '0;
            o_err         <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Fibonacci taps 16,14,13,11
            lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            o_start  <= (state_d == START);
            o_valid  <= pulse;
            o_finish <= (state_d == DONE);
            o_busy   <= (state_d == START) || (state_d == WAIT) || (state_d == ISSUE);
            if (pulse) o_at <= choice;
            if (state_d == START) o_first_st <= i_first_st;

            if (run_ok) begin
                o_episode_cnt <= '0;
                o_step_cnt    <= '0;
            end else if (ep_end) begin
                o_episode_cnt <= ep_inc;
                // the final step count stays visible in DONE
                o_step_cnt    <= (ep_inc == NUM_EP16) ? step_inc : 16'd0;
            end else if (step_done) begin
                o_step_cnt    <= step_inc;
            end

            if (run_ok) o_err <= 1'b0;
            if (i_valid_max && (state_q != WAIT)) o_err <= 1'b1;
        end
    end

`ifdef QLEARN_EPS_DECAY_EN
    logic [7:0] eps_sub;
    assign eps_sub = (eps_q > EPS_STEP) ? (eps_q - EPS_STEP) : 8'd0;

    always_ff @(posedge clk) begin
        if (rst || run_ok) begin
            eps_q <= EPS_INIT;
        end else if (ep_end) begin
            eps_q <= (eps_sub < EPS_MIN) ? EPS_MIN : eps_sub;
        end
    end
`else
    logic unused_eps;
    assign eps_q      = EPS_INIT;
    assign unused_eps = ^{EPS_STEP, EPS_MIN};
`endif

endmodule

// File: tb/tb_qlearn_episode_ctrl.sv
// Scoreboard bench for qlearn_episode_ctrl: three instances (greedy, exploring, decaying eps).
// Honours QLEARN_EPS_DECAY_EN for the expected eps trajectory.
module tb_qlearn_episode_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic        start;
        logic        valid;
        logic        finish;
        logic [1:0]  at;
        logic [3:0]  first;
        logic [15:0] ep;
        logic [15:0] step;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst, run, vmax;
    logic [2:0][3:0]  first_st, st;
    logic [2:0][1:0]  best;
    logic [2:0]       start_o, valid_o, finish_o, busy_o, err_o;
    logic [2:0][1:0]  at_o;
    logic [2:0][3:0]  first_o;
    logic [2:0][15:0] ep_o, step_o;

    qlearn_episode_ctrl #(.MAX_STEPS(4), .NUM_EPISODES(2), .EPS_INIT(8'd0), .EPS_MIN(8'd0)) u_a (
        .clk(clk), .rst(rst[0]), .i_run(run[0]), .i_first_st(first_st[0]), .i_best_at(best[0]),
        .i_st(st[0]), .i_valid_max(vmax[0]), .o_start(start_o[0]), .o_valid(valid_o[0]),
        .o_at(at_o[0]), .o_first_st(first_o[0]), .o_finish(finish_o[0]), .o_busy(busy_o[0]),
        .o_episode_cnt(ep_o[0]), .o_step_cnt(step_o[0]), .o_err(err_o[0])
    );

    qlearn_episode_ctrl #(.EPS_INIT(8'd255), .EPS_STEP(8'd0)) u_b (
        .clk(clk), .rst(rst[1]), .i_run(run[1]), .i_first_st(first_st[1]), .i_best_at(best[1]),
        .i_st(st[1]), .i_valid_max(vmax[1]), .o_start(start_o[1]), .o_valid(valid_o[1]),
        .o_at(at_o[1]), .o_first_st(first_o[1]), .o_finish(finish_o[1]), .o_busy(busy_o[1]),
        .o_episode_cnt(ep_o[1]), .o_step_cnt(step_o[1]), .o_err(err_o[1])
    );

    qlearn_episode_ctrl #(.MAX_STEPS(1), .NUM_EPISODES(5), .EPS_INIT(8'd10), .EPS_STEP(8'd3),
                          .EPS_MIN(8'd4)) u_c (
        .clk(clk), .rst(rst[2]), .i_run(run[2]), .i_first_st(first_st[2]), .i_best_at(best[2]),
        .i_st(st[2]), .i_valid_max(vmax[2]), .o_start(start_o[2]), .o_valid(valid_o[2]),
        .o_at(at_o[2]), .o_first_st(first_o[2]), .o_finish(finish_o[2]), .o_busy(busy_o[2]),
        .o_episode_cnt(ep_o[2]), .o_step_cnt(step_o[2]), .o_err(err_o[2])
    );

    int         max_steps [3] = '{4, 64, 1};
    int         num_ep    [3] = '{2, 300, 5};
    logic [7:0] eps_init  [3] = '{8'd0, 8'd255, 8'd10};
    logic [7:0] eps_step  [3] = '{8'd1, 8'd0, 8'd3};
    logic [7:0] eps_min   [3] = '{8'd0, 8'd4, 8'd4};
    logic [7:0] want_eps  [3];

    int         m_step [3];
    int         m_ep   [3];
    logic [7:0] m_eps  [3];
    logic [2:0][15:0] m_lfsr;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_start = 0;
    int   n_valid = 0;
    int   n_greedy = 0;
    int   at_hist [4] = '{0, 0, 0, 0};
    logic tally_on = 1'b0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) m_lfsr[k] <= rst[k] ? SEED : lfsr_next(m_lfsr[k]);
    end

    // Decision uses the LFSR value present during the cycle the pulse is registered.
    function automatic logic [1:0] pick(input int k, output logic greedy);
        logic [15:0] v;
        v = m_lfsr[k];
        greedy = !(v[7:0] < m_eps[k]);
        if (greedy) return best[k];
        return 2'(v[15:8] % 8'd3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input int k, input string name, input logic [31:0] obs,
                         input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL dut%0d %s: observed %0h expected %0h", k, name, obs, want);
        end
    endtask

    task automatic check_reset(input int k);
        check(k, "rst_start", start_o[k], 0);
        check(k, "rst_valid", valid_o[k], 0);
        check(k, "rst_at", at_o[k], 0);
        check(k, "rst_first", first_o[k], 0);
        check(k, "rst_finish", finish_o[k], 0);
        check(k, "rst_busy", busy_o[k], 0);
        check(k, "rst_ep", ep_o[k], 0);
        check(k, "rst_step", step_o[k], 0);
        check(k, "rst_err", err_o[k], 0);
    endtask

    task automatic check_pulse(input int k);
        exp_t e;
        check(k, "sb_pending", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check(k, "o_start", start_o[k], e.start);
        check(k, "o_valid", valid_o[k], e.valid);
        check(k, "o_finish", finish_o[k], e.finish);
        check(k, "o_busy", busy_o[k], !e.finish);
        check(k, "o_episode_cnt", ep_o[k], e.ep);
        if (e.valid) begin
            check(k, "o_at", at_o[k], e.at);
            check(k, "o_step_cnt", step_o[k], e.step);
            if (tally_on && k == 1) begin
                at_hist[at_o[k]]++;
                check(k, "o_at_legal", at_o[k] < 2'd3, 1);
            end
        end
        if (e.start) check(k, "o_first_st", first_o[k], e.first);
        if (k == 0) begin
            n_start += int'(start_o[0]);
            n_valid += int'(valid_o[0]);
        end
    endtask

    task automatic start_run(input int k);
        exp_t e;
        logic g;
        run[k] = 1'b1;
        e = '0;
        e.start = 1'b1;
        e.valid = 1'b1;
        e.at = pick(k, g);
        e.first = first_st[k];
        m_step[k] = 0;
        m_ep[k] = 0;
        m_eps[k] = eps_init[k];
        sb.push_back(e);
        tick();
        run[k] = 1'b0;
        check_pulse(k);
    endtask

    // Answer the last pulse with i_valid_max 'gap' cycles after it.
    task automatic step(input int k, input int gap, input logic [3:0] st_v,
                        input logic [1:0] best_v);
        exp_t e;
        logic g;
        int   ns;
        for (int i = 1; i < gap; i++) begin
            tick();
            check(k, "no_pulse", valid_o[k], 0);
        end
        tick();
        st[k] = st_v;
        best[k] = best_v;
        vmax[k] = 1'b1;
        e = '0;
        e.at = pick(k, g);
        if (tally_on && k == 1 && g) n_greedy++;
        ns = m_step[k] + 1;
        if (st_v == 4'd15 || ns == max_steps[k]) begin
            m_ep[k]++;
            m_step[k] = 0;
`ifdef QLEARN_EPS_DECAY_EN
            begin : decay
                logic [7:0] d;
                d = (m_eps[k] > eps_step[k]) ? m_eps[k] - eps_step[k] : 8'd0;
                m_eps[k] = (d < eps_min[k]) ? eps_min[k] : d;
            end
`endif
            e.ep = 16'(m_ep[k]);
            if (m_ep[k] == num_ep[k]) begin
                e.finish = 1'b1;
                e.step = 16'(ns);
            end else begin
                e.start = 1'b1;
                e.valid = 1'b1;
                e.first = first_st[k];
            end
        end else begin
            m_step[k] = ns;
            e.valid = 1'b1;
            e.step = 16'(ns);
            e.ep = 16'(m_ep[k]);
        end
        sb.push_back(e);
        tick();
        vmax[k] = 1'b0;
        check_pulse(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
`ifdef QLEARN_EPS_DECAY_EN
        want_eps = '{8'd7, 8'd4, 8'd4};
`else
        want_eps = '{8'd10, 8'd10, 8'd10};
`endif
        rst = '1; run = '0; vmax = '0; first_st = '0; st = '0; best = '0;
        for (int k = 0; k < 3; k++) begin
            m_eps[k] = eps_init[k];
            m_step[k] = 0;
            m_ep[k] = 0;
        end
        tick();
        tick();
        rst = '0;
        for (int k = 0; k < 3; k++) check_reset(k);

        // Greedy sequencing on A, with an ignored i_run while in WAIT
        best[0] = 2'd2;
        first_st[0] = 4'd3;
        start_run(0);
        tick();
        run[0] = 1'b1;
        tick();
        run[0] = 1'b0;
        check(0, "run_in_wait_valid", valid_o[0], 0);
        check(0, "run_in_wait_start", start_o[0], 0);
        check(0, "run_in_wait_busy", busy_o[0], 1);
        check(0, "run_in_wait_err", err_o[0], 0);
        step(0, 1, 4'd1, 2'd2);
        for (int i = 1; i < 8; i++) step(0, 3, 4'd1, 2'd2);
        check(0, "n_start", n_start, 2);
        check(0, "n_valid", n_valid, 8);

        // i_valid_max in DONE: flagged, no state change; i_run restarts
        tick();
        vmax[0] = 1'b1;
        tick();
        vmax[0] = 1'b0;
        check(0, "done_err", err_o[0], 1);
        check(0, "done_finish", finish_o[0], 1);
        check(0, "done_busy", busy_o[0], 0);
        check(0, "done_ep", ep_o[0], 2);
        check(0, "done_valid", valid_o[0], 0);
        start_run(0);
        step(0, 3, 4'd1, 2'd2);

        // Reset held 3 cycles mid-WAIT
        tick();
        tick();
        rst[0] = 1'b1;
        tick();
        check_reset(0);
        tick();
        tick();
        rst[0] = 1'b0;
        check_reset(0);
        tick();
        vmax[0] = 1'b1;
        tick();
        vmax[0] = 1'b0;
        check(0, "idle_err", err_o[0], 1);
        check(0, "idle_busy", busy_o[0], 0);
        check(0, "idle_valid", valid_o[0], 0);

        // Goal exit on B: start state changes before the goal step
        first_st[1] = 4'd5;
        start_run(1);
        step(1, 3, 4'd2, 2'd0);
        first_st[1] = 4'd9;
        step(1, 3, 4'd15, 2'd1);

        // Exploration on B
        tally_on = 1'b1;
        for (int i = 0; i < 3000; i++) step(1, 1, 4'($urandom_range(14)), 2'($urandom_range(2)));
        tally_on = 1'b0;
        for (int a = 0; a < 3; a++) begin
            check(1, "at_hist_range", (at_hist[a] >= 800) && (at_hist[a] <= 1200), 1);
        end
        check(1, "at_hist_illegal", at_hist[3], 0);
        check(1, "greedy_lt_30", n_greedy < 30, 1);

        // Epsilon trajectory on C (one step per episode)
        best[2] = 2'd1;
        start_run(2);
        for (int i = 0; i < 3; i++) begin
            step(2, 2, 4'd0, 2'd1);
            check(2, "eps", u_c.eps_q, want_eps[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
